// File: rtl/serial_deserializer.sv
// Serial-to-parallel bit collector for the correlator front end.
// Supports block mode (one word per WIDTH bits) and sliding-window mode (one word per bit).
module serial_deserializer #(
  parameter int WIDTH     = 3,
  parameter int INVERT    = 1,
  parameter int MSB_FIRST = 1,
  parameter int SLIDING   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in,
  input  logic                       in_valid,
  input  logic                       sync,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  output logic [$clog2(WIDTH)-1:0]   bit_idx,
  output logic                       filled
);

  localparam int             IW   = $clog2(WIDTH);
  localparam logic [IW-1:0]  LAST = IW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             filled_q, filled_d;

  logic             b;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fresh;

  always_comb begin
    b       = (INVERT != 0) ? ~in : in;
    shifted = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], b} : {b, sreg_q[WIDTH-1:1]};
    // A resync bit lands where a first bit would after shifting into an empty register.
    fresh   = (MSB_FIRST != 0) ? {{(WIDTH-1){1'b0}}, b} : {b, {(WIDTH-1){1'b0}}};

    sreg_d      = sreg_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    idx_d       = idx_q;
    filled_d    = filled_q;

    if (sync) begin
      if (in_valid) begin
        sreg_d = fresh;
        idx_d  = IW'(1);
      end else begin
        sreg_d = '0;
        idx_d  = '0;
      end
      filled_d = 1'b0;
    end else if (in_valid) begin
      sreg_d = shifted;
      if (SLIDING != 0) begin
        // Fill counter saturates at WIDTH-1; every bit after that emits a window.
        if (filled_q || (idx_q == LAST)) begin
          out_d       = shifted;
          out_valid_d = 1'b1;
          filled_d    = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else if (idx_q == LAST) begin
        out_d       = shifted;
        out_valid_d = 1'b1;
        idx_d       = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      filled_q    <= 1'b0;
    end else begin
      sreg_q      <= sreg_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      filled_q    <= filled_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign bit_idx   = idx_q;
  assign filled    = (SLIDING != 0) ? filled_q : 1'b0;

endmodule
